// File: rtl/mul_div_unit.sv
// Iterative radix-2 unsigned multiply/divide for the execute stage.
// Writes one result per op through a single-cycle register-file strobe.
module mul_div_unit #(
  parameter int register_width = 32,
  parameter int register_num   = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [1:0]                      op,
  input  logic [register_width-1:0]       operand_a,
  input  logic [register_width-1:0]       operand_b,
  input  logic [$clog2(register_num)-1:0] dest_address,
  output logic                            busy,
  output logic                            write_word_enable,
  output logic [$clog2(register_num)-1:0] write_reg_address,
  output logic [register_width-1:0]       write_data
);

  localparam int W  = register_width;
  localparam int AW = $clog2(register_num);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_n;

  logic [1:0]    op_q;
  logic [W-1:0]  m_q;
  logic [W-1:0]  hi, lo;
  logic [W-1:0]  hi_n, lo_n;
  logic [AW-1:0] dest_q;
  logic [CW-1:0] count;
  logic [W:0]    prod;
  logic [W:0]    shifted;
  logic [W:0]    diff;
  logic          last;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    last    = 1'b0;
    unique case (state)
      IDLE: if (start) state_n = BUSY;
      BUSY: begin
        if (count == LAST) begin
          state_n = DONE;
          last    = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // hi:lo is product/lo-multiplier for MUL, remainder/quotient for DIV;
  // so lo carries low word or quotient, hi carries high word or remainder.
  always_comb begin
    hi_n    = hi;
    lo_n    = lo;
    prod    = {1'b0, hi};
    shifted = {hi, lo[W-1]};
    diff    = shifted - {1'b0, m_q};
    if (lo[0]) prod = {1'b0, hi} + {1'b0, m_q};
    unique case (1'b1)
      op_q[1]: begin
        if (shifted >= {1'b0, m_q}) begin
          hi_n = diff[W-1:0];
          lo_n = {lo[W-2:0], 1'b1};
        end else begin
          hi_n = shifted[W-1:0];
          lo_n = {lo[W-2:0], 1'b0};
        end
      end
      default: begin
        hi_n = prod[W:1];
        lo_n = {prod[0], lo[W-1:1]};
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q              <= '0;
      m_q               <= '0;
      hi                <= '0;
      lo                <= '0;
      dest_q            <= '0;
      count             <= '0;
      busy              <= 1'b0;
      write_word_enable <= 1'b0;
      write_reg_address <= '0;
      write_data        <= '0;
    end else begin
      busy              <= (state_n != IDLE);
      write_word_enable <= last;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            m_q    <= op[1] ? operand_b : operand_a;
            lo     <= op[1] ? operand_a : operand_b;
            hi     <= '0;
            dest_q <= dest_address;
            count  <= '0;
          end
        end
        BUSY: begin
          hi    <= hi_n;
          lo    <= lo_n;
          count <= count + 1'b1;
          if (last) begin
            write_data        <= op_q[0] ? hi_n : lo_n;
            write_reg_address <= dest_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops
// against an arithmetic reference model and a register-array stand-in.
module tb_mul_div_unit;

  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    op = '0;
  logic [W-1:0]  operand_a = '0;
  logic [W-1:0]  operand_b = '0;
  logic [AW-1:0] dest_address = '0;
  logic          busy;
  logic          write_word_enable;
  logic [AW-1:0] write_reg_address;
  logic [W-1:0]  write_data;

  int tests = 0;
  int fails = 0;
  int strobes = 0;
  int s_ref;

  logic [W-1:0] regs [2**AW];

  mul_div_unit #(
    .register_width(W),
    .register_num(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .op(op),
    .operand_a(operand_a),
    .operand_b(operand_b),
    .dest_address(dest_address),
    .busy(busy),
    .write_word_enable(write_word_enable),
    .write_reg_address(write_reg_address),
    .write_data(write_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (write_word_enable) begin
      regs[write_reg_address] <= write_data;
      strobes <= strobes + 1;
    end
  end

  function automatic logic [W-1:0] model(
    input logic [1:0] o,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (o)
      2'd0:    return p[W-1:0];
      2'd1:    return p[2*W-1:W];
      2'd2:    return (b == 0) ? {W{1'b1}} : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [AW-1:0] d,
                        input bit intrude);
    int n;
    int s0;
    logic [W-1:0] exp;
    exp = model(o, a, b);
    @(negedge clk);
    op = o;
    operand_a = a;
    operand_b = b;
    dest_address = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    operand_a = $urandom;
    operand_b = $urandom;
    op = 2'($urandom);
    dest_address = AW'($urandom);
    s0 = strobes;
    @(negedge clk);
    check("busy_after_start", 64'(busy), 64'd1);
    n = 0;
    while (n < 40) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (write_word_enable) break;
      if (intrude && n == 5) begin
        start = 1'b1;
        op = 2'd0;
        operand_a = 3;
        operand_b = 3;
        dest_address = 9;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("latency_edges", 64'(n), 64'd32);
    check("write_data", 64'(write_data), 64'(exp));
    check("write_addr", 64'(write_reg_address), 64'(d));
    @(negedge clk);
    check("strobe_is_pulse", 64'(write_word_enable), 64'd0);
    check("busy_cleared", 64'(busy), 64'd0);
    check("data_held", 64'(write_data), 64'(exp));
    check("regfile_readback", 64'(regs[d]), 64'(exp));
    check("one_strobe", 64'(strobes - s0), 64'd1);
  endtask

  initial begin
    logic [1:0]   ro;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_we", 64'(write_word_enable), 64'd0);
    check("rst_data", 64'(write_data), 64'd0);
    check("rst_addr", 64'(write_reg_address), 64'd0);
    rst = 1'b0;

    run_op(2'd0, 7, 6, 5, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 1'b0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, 1'b0);
    run_op(2'd2, 100, 7, 6, 1'b0);
    run_op(2'd3, 100, 7, 7, 1'b0);
    run_op(2'd2, 55, 0, 8, 1'b0);
    run_op(2'd3, 55, 0, 0, 1'b0);
    run_op(2'd0, 12345, 678, 10, 1'b1);
    run_op(2'd3, 32'h8000_0001, 32'hFFFF_FFFF, 12, 1'b1);

    @(negedge clk);
    op = 2'd2;
    operand_a = 1000000;
    operand_b = 13;
    dest_address = 11;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    s_ref = strobes;
    rst = 1'b1;
    start = 1'b1;
    op = 2'd0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_we", 64'(write_word_enable), 64'd0);
    rst = 1'b0;
    start = 1'b0;
    repeat (40) @(negedge clk);
    check("abort_no_strobe", 64'(strobes - s_ref), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);
    run_op(2'd2, 1000000, 13, 11, 1'b0);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 0;
        1:       rb = $urandom_range(1, 255);
        default: rb = $urandom;
      endcase
      run_op(ro, ra, rb, AW'($urandom), (i % 4) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
